// File: rtl/apb_slave_pkg.sv
// rtl/apb_slave_pkg.sv - shared types and widths for the APB register slave
package apb_slave_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;
  localparam logic [ADDR_W-1:0] ID_ADDR = '0;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_e;

endpackage

// File: rtl/apb_slave_if.sv
// rtl/apb_slave_if.sv - APB bus bundle with master and slave views
interface apb_slave_if;
  import apb_slave_pkg::*;

  logic              PSELx;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic              PREADY;
  logic [DATA_W-1:0] PRDATA;
  logic              PSLVERR;

  modport master (
    output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    input  PREADY, PRDATA, PSLVERR
  );

  modport slave (
    input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
    output PREADY, PRDATA, PSLVERR
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// rtl/apb_slave_regfile.sv - register storage, one write port and one combinational read port
module apb_slave_regfile
  import apb_slave_pkg::*;
#(
  parameter int DEPTH = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];

  // Entry 0 is the ID slot and never stored; it stays a constant zero.
  always_comb begin
    mem_d = mem_q;
    rdata = '0;
    for (int i = 1; i < DEPTH; i++) begin
      if (we && waddr == i[ADDR_W-1:0]) mem_d[i] = wdata;
      if (raddr == i[ADDR_W-1:0]) rdata = mem_q[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_q <= '{default: '0};
    else     mem_q <= mem_d;
  end

endmodule

// File: rtl/apb_slave.sv
// rtl/apb_slave.sv - APB slave FSM, wait counter and error decode over a register file
// APB_SLAVE_WAIT_EN enables WAIT_CYCLES wait states; otherwise transfers take two cycles.
module apb_slave
  import apb_slave_pkg::*;
#(
  parameter int          DEPTH       = 24,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        PCLK,
  input  logic        PRESET,
  apb_slave_if.slave  bus
);

  if (DEPTH < 1 || DEPTH > 32 || WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_param
    $error("apb_slave: DEPTH must be 1..32 and WAIT_CYCLES 0..7");
  end

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cnt_zero;
  logic              ready, err, we;
  logic [DATA_W-1:0] rf_rdata, rd_word;

`ifdef APB_SLAVE_WAIT_EN
  localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);
  logic [2:0] cnt_q, cnt_d;
  assign cnt_zero = (cnt_q == '0);
`else
  assign cnt_zero = 1'b1;
`endif

  // SETUP is resident during the first enable cycle, so the counter is loaded as
  // the address is latched and a zero-wait transfer completes right there.
  assign ready = (state_q != IDLE) && bus.PSELx && bus.PENABLE && cnt_zero;
  assign err   = (int'(addr_q) >= DEPTH) || (write_q && addr_q == ID_ADDR);
  assign we    = ready && write_q && !err;

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    write_d = write_q;
    wdata_d = wdata_q;
`ifdef APB_SLAVE_WAIT_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.PSELx && !bus.PENABLE) begin
          state_d = SETUP;
          addr_d  = bus.PADDR;
          write_d = bus.PWRITE;
          wdata_d = bus.PWDATA;
`ifdef APB_SLAVE_WAIT_EN
          cnt_d   = WAIT_LOAD;
`endif
        end
      end
      SETUP, ACCESS: begin
        if (!bus.PSELx) begin
          state_d = IDLE;
        end else if (!bus.PENABLE) begin
          state_d = SETUP;
          addr_d  = bus.PADDR;
          write_d = bus.PWRITE;
          wdata_d = bus.PWDATA;
`ifdef APB_SLAVE_WAIT_EN
          cnt_d   = WAIT_LOAD;
`endif
        end else if (ready) begin
          state_d = IDLE;
        end else begin
          state_d = ACCESS;
`ifdef APB_SLAVE_WAIT_EN
          cnt_d   = cnt_q - 3'd1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      write_q <= write_d;
      wdata_q <= wdata_d;
`ifdef APB_SLAVE_WAIT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  apb_slave_regfile #(.DEPTH(DEPTH)) u_regfile (
    .clk   (PCLK),
    .rst   (PRESET),
    .we    (we),
    .waddr (addr_q),
    .wdata (wdata_q),
    .raddr (addr_q),
    .rdata (rf_rdata)
  );

  assign rd_word     = (addr_q == ID_ADDR) ? ID_VALUE : rf_rdata;
  assign bus.PREADY  = ready;
  assign bus.PSLVERR = ready && err;
  assign bus.PRDATA  = (ready && !write_q && !err) ? rd_word : '0;

endmodule

// File: tb/tb_apb_slave.sv
// tb/tb_apb_slave.sv - directed self-checking bench for apb_slave
module tb_apb_slave;

`ifdef APB_SLAVE_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif
  localparam logic [31:0] ID_VAL = 32'hA9B0_0001;
  localparam int          DEPTH  = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  apb_slave_if bus();

  apb_slave #(.DEPTH(DEPTH), .WAIT_CYCLES(2), .ID_VALUE(ID_VAL)) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .bus    (bus)
  );

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] model [32];

  task automatic bus_idle();
    bus.PSELx   = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = '0;
    bus.PWDATA  = '0;
  endtask

  // One transfer; address/data/direction are scrambled during the access phase.
  // n is the number of access cycles up to and including PREADY (99 on timeout).
  task automatic do_xfer(input logic wr, input logic [4:0] a, input logic [31:0] wd,
                         output logic [31:0] rd, output logic er, output int n);
    logic got;
    @(posedge clk); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = wr; bus.PADDR = a; bus.PWDATA = wd;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1; bus.PWRITE = ~wr; bus.PADDR = ~a; bus.PWDATA = ~wd;
    n = 0; rd = '0; er = 1'b0; got = 1'b0;
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      n++;
      if (bus.PREADY) begin
        rd = bus.PRDATA; er = bus.PSLVERR; got = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!got) n = 99;
    @(posedge clk); #1;
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b1; bus.PWRITE = 1'b0; bus.PADDR = '0; bus.PWDATA = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL reset_pready got=%b exp=0", bus.PREADY); end
    checks++; if (bus.PSLVERR !== 1'b0) begin failures++; $display("FAIL reset_pslverr got=%b exp=0", bus.PSLVERR); end
    checks++; if (bus.PRDATA !== 32'h0) begin failures++; $display("FAIL reset_prdata got=%h exp=0", bus.PRDATA); end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int n;
    do_xfer(1'b1, 5'd3, 32'hDEAD_BEEF, rd, er, n);
    model[3] = 32'hDEAD_BEEF;
    checks++; if (n !== EXP_WAIT + 1) begin failures++; $display("FAIL wr3_latency got=%0d exp=%0d", n, EXP_WAIT + 1); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL wr3_pslverr got=%b exp=0", er); end
    do_xfer(1'b0, 5'd3, 32'h0, rd, er, n);
    checks++; if (n !== EXP_WAIT + 1) begin failures++; $display("FAIL rd3_latency got=%0d exp=%0d", n, EXP_WAIT + 1); end
    checks++; if (er !== 1'b0) begin failures++; $display("FAIL rd3_pslverr got=%b exp=0", er); end
    checks++; if (rd !== 32'hDEAD_BEEF) begin failures++; $display("FAIL rd3_data got=%h exp=deadbeef", rd); end
  endtask

  task automatic test_id_reg();
    logic [31:0] rd; logic er; int n;
    do_xfer(1'b0, 5'd0, 32'h0, rd, er, n);
    checks++; if (rd !== ID_VAL || er !== 1'b0) begin failures++; $display("FAIL id_read got=%h/%b exp=%h/0", rd, er, ID_VAL); end
    do_xfer(1'b1, 5'd0, 32'h0000_1234, rd, er, n);
    checks++; if (er !== 1'b1) begin failures++; $display("FAIL id_write_err got=%b exp=1", er); end
    checks++; if (n !== EXP_WAIT + 1) begin failures++; $display("FAIL id_write_latency got=%0d exp=%0d", n, EXP_WAIT + 1); end
    do_xfer(1'b0, 5'd0, 32'h0, rd, er, n);
    checks++; if (rd !== ID_VAL) begin failures++; $display("FAIL id_reread got=%h exp=%h", rd, ID_VAL); end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; logic er; int n;
    do_xfer(1'b0, 5'd30, 32'h0, rd, er, n);
    checks++; if (er !== 1'b1 || rd !== 32'h0) begin failures++; $display("FAIL oor_read got=%h/%b exp=0/1", rd, er); end
    do_xfer(1'b1, 5'd30, 32'hCAFE_F00D, rd, er, n);
    checks++; if (er !== 1'b1 || n !== EXP_WAIT + 1) begin failures++; $display("FAIL oor_write got=%b/%0d exp=1/%0d", er, n, EXP_WAIT + 1); end
    for (int a = 1; a < DEPTH; a++) begin
      do_xfer(1'b0, 5'(a), 32'h0, rd, er, n);
      checks++; if (rd !== model[a] || er !== 1'b0) begin failures++; $display("FAIL oor_keep_%0d got=%h exp=%h", a, rd, model[a]); end
    end
  endtask

  task automatic test_abort();
    logic [31:0] rd; logic er; int n;
    int drop;
    drop = (EXP_WAIT > 0) ? 2 : 1;
    @(posedge clk); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'd5; bus.PWDATA = 32'h55;
    for (int c = 1; c <= drop; c++) begin
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      bus.PSELx = (c < drop);
      @(negedge clk);
      checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL abort_pready_c%0d got=%b exp=0", c, bus.PREADY); end
    end
    @(posedge clk); #1;
    bus_idle();
    do_xfer(1'b0, 5'd5, 32'h0, rd, er, n);
    checks++; if (rd !== 32'h0 || n !== EXP_WAIT + 1) begin failures++; $display("FAIL abort_rd5 got=%h/%0d exp=0/%0d", rd, n, EXP_WAIT + 1); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; logic er; int n;
    do_xfer(1'b1, 5'd7, 32'h0000_00FF, rd, er, n);
    model[7] = 32'hFF;
    @(posedge clk); #1;
    bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b1; bus.PADDR = 5'd7; bus.PWDATA = 32'hAB;
    @(posedge clk); #1;
    bus.PENABLE = 1'b1;
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.PREADY !== 1'b0 || bus.PSLVERR !== 1'b0 || bus.PRDATA !== 32'h0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%h exp=0/0/0", bus.PREADY, bus.PSLVERR, bus.PRDATA);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    bus_idle();
    for (int a = 0; a < 32; a++) model[a] = '0;
    do_xfer(1'b0, 5'd7, 32'h0, rd, er, n);
    checks++; if (rd !== 32'h0 || er !== 1'b0 || n !== EXP_WAIT + 1) begin
      failures++; $display("FAIL rstmid_rd7 got=%h/%b/%0d exp=0/0/%0d", rd, er, n, EXP_WAIT + 1);
    end
    do_xfer(1'b0, 5'd3, 32'h0, rd, er, n);
    checks++; if (rd !== 32'h0) begin failures++; $display("FAIL rstmid_rd3 got=%h exp=0", rd); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic er; int n;
    logic got;
    do_xfer(1'b1, 5'd1, 32'h0000_0011, rd, er, n);
    do_xfer(1'b1, 5'd2, 32'h0000_0022, rd, er, n);
    model[1] = 32'h11; model[2] = 32'h22;
    @(posedge clk); #1;
    for (int j = 1; j <= 2; j++) begin
      bus.PSELx = 1'b1; bus.PENABLE = 1'b0; bus.PWRITE = 1'b0; bus.PADDR = 5'(j); bus.PWDATA = '0;
      @(negedge clk);
      checks++; if (bus.PREADY !== 1'b0) begin failures++; $display("FAIL b2b_setup%0d_pready got=%b exp=0", j, bus.PREADY); end
      @(posedge clk); #1;
      bus.PENABLE = 1'b1;
      n = 0; rd = '0; got = 1'b0;
      for (int k = 0; k < 16; k++) begin
        @(negedge clk);
        n++;
        if (bus.PREADY) begin rd = bus.PRDATA; got = 1'b1; break; end
        @(posedge clk); #1;
      end
      if (!got) n = 99;
      checks++; if (n !== EXP_WAIT + 1) begin failures++; $display("FAIL b2b_latency%0d got=%0d exp=%0d", j, n, EXP_WAIT + 1); end
      checks++; if (rd !== model[j]) begin failures++; $display("FAIL b2b_data%0d got=%h exp=%h", j, rd, model[j]); end
      @(posedge clk); #1;
    end
    bus_idle();
  endtask

  initial begin
    for (int a = 0; a < 32; a++) model[a] = '0;
    bus_idle();
    test_reset();
    test_write_read();
    test_id_reg();
    test_out_of_range();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apb_slave.md
APB_SLAVE -- requirements
Module: apb_slave

Interface
REQ-001 SHALL provide parameter DEPTH, default 24: number of implemented 32-bit registers at word addresses 0..DEPTH-1, with DEPTH <= 32.
REQ-002 SHALL provide parameter WAIT_CYCLES, default 2: wait states inserted per transfer, range 0..7.
REQ-003 SHALL provide parameter ID_VALUE, default 32'hA9B0_0001: read-only contents of address 0.
REQ-004 PCLK  input  1  clock; all state changes on its rising edge.
REQ-005 PRESET  input  1  reset; one clock, reset is asynchronous and active-high.
REQ-006 PSELx  input  1  slave select from the master.
REQ-007 PENABLE  input  1  high in the access phase.
REQ-008 PWRITE  input  1  1 = write, 0 = read.
REQ-009 PADDR  input  5  word address.
REQ-010 PWDATA  input  32  write data.
REQ-011 PREADY  output  1  transfer completes in this access cycle.
REQ-012 PRDATA  output  32  read data, valid only while PREADY=1 on a read.
REQ-013 PSLVERR  output  1  error response, valid only while PREADY=1.

Function
REQ-014 FSM states SHALL be IDLE, SETUP and ACCESS.
REQ-015 IDLE->SETUP SHALL occur when PSELx=1 and PENABLE=0, with PADDR, PWRITE and PWDATA latched on that edge.
REQ-016 SETUP->ACCESS SHALL occur unconditionally, loading the wait counter with WAIT_CYCLES.
REQ-017 In ACCESS with PSELx=1 and PENABLE=1, the counter SHALL decrement each cycle while nonzero.
REQ-018 PREADY SHALL be 1 exactly in ACCESS cycles where the counter is 0 and PENABLE=1, so a transfer lasts WAIT_CYCLES+2 cycles including setup.
REQ-019 A write SHALL commit to the latched address on the edge ending the PREADY=1 cycle, and only if PSLVERR=0.
REQ-020 On a read, PRDATA SHALL equal the register (or ID_VALUE at address 0) when PREADY=1; otherwise PRDATA SHALL be 0.
REQ-021 PSLVERR SHALL assert with PREADY for latched address >= DEPTH, or for a write to address 0; such transfers SHALL leave all storage unchanged, and a failing read SHALL return PRDATA=0.
REQ-022 After the PREADY=1 cycle, the FSM SHALL go to SETUP if PSELx=1 and PENABLE=0 (back-to-back), and to IDLE otherwise.
REQ-023 If PSELx falls in ACCESS before PREADY, the FSM SHALL return to IDLE with no write and no response (abort).
REQ-024 PSELx=1 with PENABLE=0 while in ACCESS SHALL be treated as a new setup that restarts the transfer, abandoning the old one.
REQ-025 Changes on PADDR, PWRITE or PWDATA after SETUP SHALL be ignored until the next transfer.

Reset
REQ-026 PRESET=1 SHALL immediately force IDLE, counter to 0, PREADY, PSLVERR and PRDATA to 0, and registers 1..DEPTH-1 to 0.
REQ-027 Reset asserted mid-transfer SHALL abort the transfer without committing the write.
REQ-028 After reset release, the first transfer SHALL be accepted on the next valid setup cycle.

Configuration
REQ-029 Macro APB_SLAVE_WAIT_EN defined: wait states per WAIT_CYCLES as above.
REQ-030 Macro APB_SLAVE_WAIT_EN undefined: WAIT_CYCLES SHALL be ignored, the counter SHALL be absent, and PREADY SHALL be 1 in the first access cycle (2-cycle transfers).

Structure
REQ-031 Package apb_slave_pkg SHALL hold the state typedef (IDLE/SETUP/ACCESS), the address width (5), the data width (32) and the ID register address (0).
REQ-032 Storage SHALL be sub-module apb_slave_regfile, with one write port and one combinational read port; the FSM, counter and error decode SHALL stay in apb_slave.

Verification
REQ-033 Write 32'hDEAD_BEEF to address 3, then read address 3, with WAIT_CYCLES=2 -> PREADY on the 4th cycle of each transfer; read PRDATA=32'hDEAD_BEEF; PSLVERR=0.
REQ-034 Read address 0, then write 32'h1234 to address 0 -> read returns 32'hA9B0_0001; write gets PSLVERR=1; a re-read still returns 32'hA9B0_0001.
REQ-035 Read and write address 30 with DEPTH=24 -> PSLVERR=1 with PREADY and PRDATA=0; registers 1..23 unchanged.
REQ-036 Drop PSELx in the 2nd access cycle of a write of 32'h55 to address 5 -> no PREADY; address 5 still reads 0.
REQ-037 Assert PRESET mid-write to address 7 after writing 32'hFF to address 7 -> outputs 0 immediately; address 7 reads 0 after release.
REQ-038 Run back-to-back reads of addresses 1 and 2 with APB_SLAVE_WAIT_EN undefined -> each completes in 2 cycles with PREADY in every access cycle.
